// File: rtl/fft_input_reorder.sv
// rtl/fft_input_reorder.sv - ping-pong buffer that re-emits natural-order blocks in bit-reversed order
module fft_input_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LDN    = 11
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys,
    input  logic                  block_sync_i,
    input  logic                  data_val_i,
    input  logic [DATA_WIDTH-1:0] data_real_i,
    input  logic [DATA_WIDTH-1:0] data_imag_i,
    input  logic [3:0]            ldn_rg_i,
    output logic                  block_sync_o,
    output logic                  data_val_o,
    output logic [DATA_WIDTH-1:0] data_real_o,
    output logic [DATA_WIDTH-1:0] data_imag_o,
    output logic [3:0]            ldn_rg_o,
    output logic                  err_short_o
);
    localparam int         DEPTH   = 1 << MAX_LDN;
    localparam logic [3:0] LDN_MAX = 4'(MAX_LDN);

    function automatic logic [3:0] legal_ldn(input logic [3:0] l);
        return (l >= 4'd2 && l <= LDN_MAX) ? l : LDN_MAX;
    endfunction

    function automatic logic [MAX_LDN-1:0] last_idx(input logic [3:0] l);
        return {MAX_LDN{1'b1}} >> (LDN_MAX - l);
    endfunction

    // Reversing all MAX_LDN bits then shifting down leaves the low ldn bits reversed.
    function automatic logic [MAX_LDN-1:0] bitrev(input logic [MAX_LDN-1:0] k, input logic [3:0] l);
        logic [MAX_LDN-1:0] r;
        for (int i = 0; i < MAX_LDN; i++) r[i] = k[MAX_LDN-1-i];
        return r >> (LDN_MAX - l);
    endfunction

    logic                    wr_active;
    logic [MAX_LDN-1:0]      wr_cnt;
    logic                    wr_bank;
    logic [3:0]              wr_ldn;
    logic                    done_pulse;
    logic                    done_bank;
    logic [3:0]              done_ldn;
    logic                    rd_active;
    logic                    rd_bank;
    logic [3:0]              rd_ldn;
    logic [MAX_LDN-1:0]      rd_k;
    logic [MAX_LDN-1:0]      rd_addr;
    logic                    s1_val;
    logic                    s1_first;
    logic [3:0]              s1_ldn;
    logic [2*DATA_WIDTH-1:0] ram_q;
    logic [2*DATA_WIDTH-1:0] mem [2*DEPTH];

    logic               wr_en;
    logic               wr_last;
    logic [MAX_LDN-1:0] wr_addr;

    always_comb begin
        wr_en   = data_val_i & (block_sync_i | wr_active);
        wr_addr = block_sync_i ? '0 : wr_cnt;
        wr_last = data_val_i & ~block_sync_i & wr_active & (wr_cnt == last_idx(wr_ldn));
        rd_addr = bitrev(rd_k, rd_ldn);
    end

    // The bank flips on the completing edge so a following block never lands in the bank being read.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            wr_active   <= 1'b0;
            wr_cnt      <= '0;
            wr_bank     <= 1'b0;
            wr_ldn      <= '0;
            done_pulse  <= 1'b0;
            done_bank   <= 1'b0;
            done_ldn    <= '0;
            err_short_o <= 1'b0;
        end else begin
            done_pulse  <= 1'b0;
            err_short_o <= 1'b0;
            if (data_val_i && block_sync_i) begin
                wr_active   <= 1'b1;
                wr_cnt      <= {{(MAX_LDN-1){1'b0}}, 1'b1};
                wr_ldn      <= legal_ldn(ldn_rg_i);
                err_short_o <= wr_active;
            end else if (wr_last) begin
                wr_active  <= 1'b0;
                wr_cnt     <= '0;
                wr_bank    <= ~wr_bank;
                done_pulse <= 1'b1;
                done_bank  <= wr_bank;
                done_ldn   <= wr_ldn;
            end else if (data_val_i && wr_active) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            rd_active <= 1'b0;
            rd_bank   <= 1'b0;
            rd_ldn    <= '0;
            rd_k      <= '0;
        end else if (done_pulse) begin
            rd_active <= 1'b1;
            rd_bank   <= done_bank;
            rd_ldn    <= done_ldn;
            rd_k      <= '0;
        end else if (rd_active) begin
            if (rd_k == last_idx(rd_ldn)) rd_active <= 1'b0;
            else                          rd_k      <= rd_k + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= {data_real_i, data_imag_i};
        ram_q <= mem[{rd_bank, rd_addr}];
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            s1_val       <= 1'b0;
            s1_first     <= 1'b0;
            s1_ldn       <= '0;
            data_val_o   <= 1'b0;
            block_sync_o <= 1'b0;
            ldn_rg_o     <= '0;
            data_real_o  <= '0;
            data_imag_o  <= '0;
        end else begin
            s1_val       <= rd_active;
            s1_first     <= rd_active && (rd_k == '0);
            s1_ldn       <= rd_ldn;
            data_val_o   <= s1_val;
            block_sync_o <= s1_val & s1_first;
            if (s1_val && s1_first) ldn_rg_o <= s1_ldn;
            if (s1_val) {data_real_o, data_imag_o} <= ram_q;
        end
    end
endmodule

// File: tb/tb_fft_input_reorder.sv
// tb/tb_fft_input_reorder.sv - scoreboard bench for fft_input_reorder
module tb_fft_input_reorder;
    localparam int DW = 16;

    logic          clk_sys = 1'b0;
    logic          rst_sys = 1'b1;
    logic          block_sync_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic [DW-1:0] data_real_i = '0;
    logic [DW-1:0] data_imag_i = '0;
    logic [3:0]    ldn_rg_i = '0;
    logic          block_sync_o;
    logic          data_val_o;
    logic [DW-1:0] data_real_o;
    logic [DW-1:0] data_imag_o;
    logic [3:0]    ldn_rg_o;
    logic          err_short_o;

    fft_input_reorder #(.DATA_WIDTH(DW), .MAX_LDN(11)) dut (
        .clk_sys      (clk_sys),
        .rst_sys      (rst_sys),
        .block_sync_i (block_sync_i),
        .data_val_i   (data_val_i),
        .data_real_i  (data_real_i),
        .data_imag_i  (data_imag_i),
        .ldn_rg_i     (ldn_rg_i),
        .block_sync_o (block_sync_o),
        .data_val_o   (data_val_o),
        .data_real_o  (data_real_o),
        .data_imag_o  (data_imag_o),
        .ldn_rg_o     (ldn_rg_o),
        .err_short_o  (err_short_o)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sync;
        logic [3:0]    ldn;
        int            cyc;
    } exp_t;

    exp_t            exp_q[$];
    int              err_q[$];
    int              tests = 0;
    int              fails = 0;

    bit              blk_active = 0;
    int              blk_n = 0;
    logic [3:0]      blk_ldn = '0;
    logic [2*DW-1:0] blk_data[$];

    function automatic int rev_bits(input int k, input int l);
        int r = 0;
        for (int b = 0; b < l; b++)
            if ((k >> b) & 1) r = r | (1 << (l - 1 - b));
        return r;
    endfunction

    task automatic beat(input bit sync, input logic [3:0] ldn, input logic [DW-1:0] re, input logic [DW-1:0] im);
        int e;
        exp_t x;
        logic [2*DW-1:0] w;
        @(negedge clk_sys);
        block_sync_i = sync;
        data_val_i   = 1'b1;
        ldn_rg_i     = ldn;
        data_real_i  = re;
        data_imag_i  = im;
        e = cyc + 1;
        if (sync) begin
            if (blk_active && blk_data.size() > 0) err_q.push_back(e);
            blk_active = 1;
            blk_ldn    = (ldn >= 4'd2 && ldn <= 4'd11) ? ldn : 4'd11;
            blk_n      = 1 << blk_ldn;
            blk_data.delete();
        end
        if (blk_active) begin
            blk_data.push_back({re, im});
            if (blk_data.size() == blk_n) begin
                for (int k = 0; k < blk_n; k++) begin
                    w      = blk_data[rev_bits(k, int'(blk_ldn))];
                    x.re   = w[2*DW-1:DW];
                    x.im   = w[DW-1:0];
                    x.sync = (k == 0);
                    x.ldn  = blk_ldn;
                    x.cyc  = e + 3 + k;
                    exp_q.push_back(x);
                end
                blk_active = 0;
            end
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            data_val_i   = 1'b0;
            block_sync_i = 1'b0;
            data_real_i  = DW'($urandom);
            data_imag_i  = DW'($urandom);
        end
    endtask

    task automatic drain(input int max_cyc);
        int c = 0;
        gap(1);
        while (exp_q.size() > 0 && c < max_cyc) begin
            @(negedge clk_sys);
            c++;
        end
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d samples still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        gap(4);
    endtask

    task automatic monitor_loop();
        exp_t x;
        bit   exp_err;
        forever begin
            @(negedge clk_sys);
            if (!rst_sys) begin
                if (data_val_o) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_output: got re=%h im=%h at cyc %0d, required no output",
                                 data_real_o, data_imag_o, cyc);
                    end else begin
                        x = exp_q.pop_front();
                        if ({data_real_o, data_imag_o, block_sync_o, ldn_rg_o, 32'(cyc)} !==
                            {x.re, x.im, x.sync, x.ldn, 32'(x.cyc)}) begin
                            fails++;
                            $display("FAIL out_sample: got re=%h im=%h sync=%b ldn=%0d cyc=%0d, required re=%h im=%h sync=%b ldn=%0d cyc=%0d",
                                     data_real_o, data_imag_o, block_sync_o, ldn_rg_o, cyc,
                                     x.re, x.im, x.sync, x.ldn, x.cyc);
                        end
                    end
                end
                exp_err = (err_q.size() > 0 && err_q[0] == cyc);
                if (err_short_o || exp_err) begin
                    tests++;
                    if (exp_err) void'(err_q.pop_front());
                    if (err_short_o !== exp_err) begin
                        fails++;
                        $display("FAIL err_short: got %b at cyc %0d, required %b", err_short_o, cyc, exp_err);
                    end
                end
            end
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({block_sync_o, data_val_o, data_real_o, data_imag_o, ldn_rg_o, err_short_o} !== '0) begin
            fails++;
            $display("FAIL %s: got sync=%b val=%b re=%h im=%h ldn=%0d err=%b, required all 0",
                     name, block_sync_o, data_val_o, data_real_o, data_imag_o, ldn_rg_o, err_short_o);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk_sys);
        check_zero("reset_state");
        rst_sys = 1'b0;

        // Beats before any block start must be dropped.
        for (int i = 0; i < 5; i++) beat(0, 4'd3, DW'(100 + i), DW'(200 + i));
        gap(10);

        for (int i = 0; i < 8; i++) beat(i == 0, 4'd3, DW'(i), DW'(~i));
        drain(50);

        // Trailing beats after completion with no new sync are also dropped.
        for (int i = 0; i < 4; i++) beat(0, 4'd3, DW'(50 + i), DW'(60 + i));
        gap(10);

        for (int i = 0; i < 4; i++) begin
            beat(i == 0, 4'd2, DW'(10 + i), DW'(20 + i));
            if (i < 3) gap(1);
        end
        drain(50);

        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 2048; i++)
                beat(i == 0, 4'd11, DW'(b * 2048 + i), DW'($urandom));
        drain(2200);

        for (int i = 0; i < 5; i++) beat(i == 0, 4'd4, DW'(300 + i), DW'(400 + i));
        for (int i = 0; i < 8; i++) beat(i == 0, 4'd3, DW'(500 + i), DW'(600 + i));
        drain(50);

        for (int i = 0; i < 2048; i++) beat(i == 0, 4'd15, DW'($urandom), DW'(i));
        drain(2200);

        for (int b = 0; b < 6; b++) begin
            int l;
            l = $urandom_range(2, 7);
            for (int i = 0; i < (1 << l); i++) begin
                beat(i == 0, 4'(l), DW'($urandom), DW'($urandom));
                if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 2));
            end
            drain(300);
        end

        // Reset asserted mid-way through a 2048-point output block.
        for (int i = 0; i < 2048; i++) beat(i == 0, 4'd11, DW'(i), DW'(~i));
        gap(200);
        @(posedge clk_sys);
        #2;
        rst_sys = 1'b1;
        #1;
        check_zero("reset_async");
        exp_q.delete();
        err_q.delete();
        blk_active = 0;
        blk_data.delete();
        @(negedge clk_sys);
        check_zero("reset_hold");
        rst_sys = 1'b0;
        gap(2);

        for (int i = 0; i < 8; i++) beat(i == 0, 4'd3, DW'(i), DW'(i + 8));
        drain(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
